// File: rtl/lcd_dma_pkg.sv
// Shared AXI constants and the FSM encoding for the LCD DMA read engine.
package lcd_dma_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_8B    = 3'b011;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    localparam int LCD_DMA_WORDS_PER_BEAT = 2;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA
    } dma_state_e;

endpackage

// File: rtl/axi_rd_beat_splitter.sv
// Captures one 64-bit AXI read beat and replays it as two 32-bit words (low half first).
module axi_rd_beat_splitter
    import lcd_dma_pkg::*;
(
    input  logic        CLK,
    input  logic        RESET,
    input  logic        enable,
    input  logic        rvalid,
    input  logic [63:0] rdata,
    output logic        rready,
    output logic        beat_accept,
    output logic [31:0] word,
    output logic        word_valid,
    output logic        hi_word
);

    logic [63:0] data_reg;
    logic        lo_pend_reg;
    logic        hi_pend_reg;
    logic [31:0] half [LCD_DMA_WORDS_PER_BEAT];

    genvar gi;
    generate
        for (gi = 0; gi < LCD_DMA_WORDS_PER_BEAT; gi++) begin : g_half
            assign half[gi] = data_reg[32*gi +: 32];
        end
    endgenerate

    // The holder is free again while the high half is being emitted, so a
    // new beat can land in the same cycle and keep one word per cycle.
    assign rready      = enable & ~lo_pend_reg;
    assign beat_accept = rready & rvalid;
    assign word_valid  = lo_pend_reg | hi_pend_reg;
    assign hi_word     = hi_pend_reg;
    assign word        = lo_pend_reg ? half[0] : (hi_pend_reg ? half[1] : 32'd0);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            data_reg    <= '0;
            lo_pend_reg <= 1'b0;
            hi_pend_reg <= 1'b0;
        end else begin
            lo_pend_reg <= beat_accept;
            hi_pend_reg <= lo_pend_reg;
            if (beat_accept) begin
                data_reg <= rdata;
            end
        end
    end

endmodule

// File: rtl/lcd_dma_axi_reader.sv
// DMA engine for the LCD controller: one AXI3 INCR read burst per start,
// returned as a stream of 32-bit words.
module lcd_dma_axi_reader
    import lcd_dma_pkg::*;
#(
    parameter int         BURST_BEATS = 4,
    parameter logic [5:0] AXI_ID      = 6'd0,
    parameter logic [3:0] AR_CACHE    = 4'b0011
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [29:0] DMA_RD_ADDR,
    input  logic        DMA_START,
    output logic        DMA_READY,
    output logic [31:0] DMA_RD_DATA,
    output logic        DMA_RD_DATA_VALID,
    output logic        DMA_ERROR,
    output logic [31:0] M_ARADDR,
    output logic [3:0]  M_ARLEN,
    output logic [2:0]  M_ARSIZE,
    output logic [1:0]  M_ARBURST,
    output logic [5:0]  M_ARID,
    output logic [3:0]  M_ARCACHE,
    output logic        M_ARVALID,
    input  logic        M_ARREADY,
    input  logic [63:0] M_RDATA,
    input  logic [1:0]  M_RRESP,
    input  logic        M_RLAST,
    input  logic [5:0]  M_RID,
    input  logic        M_RVALID,
    output logic        M_RREADY
);

    localparam logic [4:0] BEAT_TOTAL = 5'(BURST_BEATS);
    localparam logic [4:0] BEAT_LAST  = 5'(BURST_BEATS - 1);

    dma_state_e  state_reg, state_next;
    logic [28:0] addr_reg;
    logic [4:0]  beat_cnt_reg;
    logic        error_reg;
    logic        split_en;
    logic        beat_accept;
    logic        hi_word;

    logic unused_inputs;
    assign unused_inputs = ^{M_RID, DMA_RD_ADDR[29]};

    assign M_ARADDR  = {addr_reg, 3'b000};
    assign M_ARLEN   = 4'(BURST_BEATS - 1);
    assign M_ARSIZE  = AXI_SIZE_8B;
    assign M_ARBURST = AXI_BURST_INCR;
    assign M_ARID    = AXI_ID;
    assign M_ARCACHE = AR_CACHE;
    assign DMA_ERROR = error_reg;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (DMA_START) state_next = ADDR;
            ADDR: if (M_ARREADY) state_next = DATA;
            DATA: if (beat_cnt_reg == BEAT_TOTAL && hi_word) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        DMA_READY = (state_reg == IDLE);
        M_ARVALID = (state_reg == ADDR);
        split_en  = (state_reg == DATA) && (beat_cnt_reg < BEAT_TOTAL);
    end

    // Termination follows the beat count; RLAST is only cross-checked.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            addr_reg     <= '0;
            beat_cnt_reg <= '0;
            error_reg    <= 1'b0;
        end else begin
            if (state_reg == IDLE && DMA_START) begin
                addr_reg     <= DMA_RD_ADDR[28:0];
                beat_cnt_reg <= '0;
            end
            if (beat_accept) begin
                beat_cnt_reg <= beat_cnt_reg + 5'd1;
                if (M_RRESP != AXI_RESP_OKAY || M_RLAST != (beat_cnt_reg == BEAT_LAST)) begin
                    error_reg <= 1'b1;
                end
            end
        end
    end

    axi_rd_beat_splitter u_splitter (
        .CLK         (CLK),
        .RESET       (RESET),
        .enable      (split_en),
        .rvalid      (M_RVALID),
        .rdata       (M_RDATA),
        .rready      (M_RREADY),
        .beat_accept (beat_accept),
        .word        (DMA_RD_DATA),
        .word_valid  (DMA_RD_DATA_VALID),
        .hi_word     (hi_word)
    );

endmodule

// File: tb/tb_lcd_dma_axi_reader.sv
// Bench for lcd_dma_axi_reader: an AXI read slave model feeding a word-order
// and sticky-error reference model, driven with randomized timing and data.
module tb_lcd_dma_axi_reader;

    localparam int BEATS = 4;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [29:0] DMA_RD_ADDR;
    logic        DMA_START;
    logic        DMA_READY;
    logic [31:0] DMA_RD_DATA;
    logic        DMA_RD_DATA_VALID;
    logic        DMA_ERROR;
    logic [31:0] M_ARADDR;
    logic [3:0]  M_ARLEN;
    logic [2:0]  M_ARSIZE;
    logic [1:0]  M_ARBURST;
    logic [5:0]  M_ARID;
    logic [3:0]  M_ARCACHE;
    logic        M_ARVALID;
    logic        M_ARREADY;
    logic [63:0] M_RDATA;
    logic [1:0]  M_RRESP;
    logic        M_RLAST;
    logic [5:0]  M_RID;
    logic        M_RVALID;
    logic        M_RREADY;

    int vectors    = 0;
    int miscompares = 0;
    bit err_model  = 1'b0;

    lcd_dma_axi_reader #(.BURST_BEATS(BEATS), .AXI_ID(6'd0), .AR_CACHE(4'b0011)) dut (
        .CLK(CLK), .RESET(RESET),
        .DMA_RD_ADDR(DMA_RD_ADDR), .DMA_START(DMA_START), .DMA_READY(DMA_READY),
        .DMA_RD_DATA(DMA_RD_DATA), .DMA_RD_DATA_VALID(DMA_RD_DATA_VALID), .DMA_ERROR(DMA_ERROR),
        .M_ARADDR(M_ARADDR), .M_ARLEN(M_ARLEN), .M_ARSIZE(M_ARSIZE), .M_ARBURST(M_ARBURST),
        .M_ARID(M_ARID), .M_ARCACHE(M_ARCACHE), .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY),
        .M_RDATA(M_RDATA), .M_RRESP(M_RRESP), .M_RLAST(M_RLAST), .M_RID(M_RID),
        .M_RVALID(M_RVALID), .M_RREADY(M_RREADY)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One request; the slave side is modelled cycle by cycle, sampling #1 after each edge.
    task automatic run_burst(input logic [29:0] addr, input int ar_delay, input int gap,
                             input int bad_resp_beat, input int early_last_beat,
                             input bit glitch, input int reset_after, input bit idx_data);
        logic [31:0] exp_q[$];
        logic [31:0] exp_araddr = {addr[28:0], 3'b000};
        logic [63:0] beat_data = '0;
        int words = 0, beats_sent = 0, ar_cycles = 0, ar_hs = 0, gap_left = 0, cyc = 0;
        bit r_hold = 1'b0;

        chk("ready_before_start", DMA_READY, 1);
        DMA_RD_ADDR = addr;
        DMA_START   = 1'b1;
        @(posedge CLK); #1;
        DMA_START   = 1'b0;
        DMA_RD_ADDR = 30'($urandom);
        chk("ready_falls", DMA_READY, 0);
        while (1) begin
            chk("error_flag", DMA_ERROR, err_model);
            if (words == 2 * BEATS) begin
                chk("ready_after_last", DMA_READY, 1);
                chk("rready_idle", M_RREADY, 0);
                chk("ar_handshakes", ar_hs, 1);
                break;
            end
            chk("ready_busy", DMA_READY, 0);
            if (DMA_RD_DATA_VALID) begin
                if (exp_q.size() == 0) chk("spurious_word", 1, 0);
                else chk("word", DMA_RD_DATA, exp_q.pop_front());
                words++;
            end else begin
                chk("idle_data_zero", DMA_RD_DATA, 0);
            end
            if (reset_after >= 0 && words == reset_after) begin
                RESET = 1'b1; M_RVALID = 1'b0; M_ARREADY = 1'b0;
                @(posedge CLK); #1;
                RESET = 1'b0;
                err_model = 1'b0;
                chk("rst_ready", DMA_READY, 1);
                chk("rst_valid", DMA_RD_DATA_VALID, 0);
                chk("rst_arvalid", M_ARVALID, 0);
                chk("rst_rready", M_RREADY, 0);
                chk("rst_error", DMA_ERROR, 0);
                return;
            end
            DMA_START = glitch && ((M_ARVALID && ar_cycles == 0) || words == 1);
            DMA_RD_ADDR = DMA_START ? ~addr : 30'($urandom);
            // R channel only opens once an AR handshake has already completed.
            if (!r_hold && ar_hs > 0 && beats_sent < BEATS) begin
                if (gap_left > 0) gap_left--;
                else begin
                    r_hold = 1'b1;
                    beat_data = idx_data ? {2{32'(beats_sent)}} : {$urandom, $urandom};
                end
            end
            M_RVALID = r_hold;
            M_RDATA  = r_hold ? beat_data : {$urandom, $urandom};
            M_RRESP  = (beats_sent == bad_resp_beat) ? 2'b10 : 2'b00;
            M_RLAST  = (early_last_beat >= 0) ? (beats_sent == early_last_beat) : (beats_sent == BEATS - 1);
            M_RID    = 6'($urandom);
            if (M_ARVALID) begin
                ar_cycles++;
                chk("araddr", M_ARADDR, exp_araddr);
                chk("arlen", M_ARLEN, BEATS - 1);
                chk("arsize", M_ARSIZE, 3);
                chk("arburst", M_ARBURST, 1);
                chk("arid", M_ARID, 0);
                chk("arcache", M_ARCACHE, 3);
                if (ar_hs != 0) chk("ar_reissued", 1, 0);
                M_ARREADY = (ar_cycles > ar_delay);
            end else begin
                M_ARREADY = 1'($urandom_range(0, 1));
            end
            if (M_ARVALID && M_ARREADY) begin
                ar_hs++;
                chk("ar_wait_cycles", ar_cycles, ar_delay + 1);
            end
            if (r_hold && M_RREADY) begin
                exp_q.push_back(beat_data[31:0]);
                exp_q.push_back(beat_data[63:32]);
                if (M_RRESP != 2'b00 || M_RLAST != (beats_sent == BEATS - 1)) err_model = 1'b1;
                beats_sent++;
                r_hold = 1'b0;
                gap_left = (gap >= 0) ? gap : int'($urandom_range(0, 3));
            end
            cyc++;
            if (cyc > 400) begin
                chk("burst_timeout", 1, 0);
                RESET = 1'b1;
                @(posedge CLK); #1;
                RESET = 1'b0;
                err_model = 1'b0;
                break;
            end
            @(posedge CLK); #1;
        end
        DMA_START = 1'b0;
        M_RVALID  = 1'b0;
        M_ARREADY = 1'b0;
    endtask

    initial begin
        RESET = 1'b1; DMA_START = 1'b0; DMA_RD_ADDR = '0; M_ARREADY = 1'b0;
        M_RDATA = '0; M_RRESP = '0; M_RLAST = 1'b0; M_RID = '0; M_RVALID = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk("reset_ready", DMA_READY, 1);
        chk("reset_valid", DMA_RD_DATA_VALID, 0);
        chk("reset_data", DMA_RD_DATA, 0);
        chk("reset_error", DMA_ERROR, 0);
        chk("reset_arvalid", M_ARVALID, 0);
        chk("reset_rready", M_RREADY, 0);
        chk("reset_araddr", M_ARADDR, 0);
        RESET = 1'b0;

        run_burst(30'h10000000, 0, 0, -1, -1, 1'b0, -1, 1'b1);
        run_burst(30'h2345678, 5, 2, -1, -1, 1'b0, -1, 1'b0);
        run_burst(30'h0ABCDEF, 2, -1, -1, -1, 1'b1, -1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            run_burst(30'($urandom), int'($urandom_range(0, 4)), -1, -1, -1,
                      1'($urandom_range(0, 1)), -1, 1'b0);
        end
        run_burst(30'($urandom), 1, -1, 2, -1, 1'b0, -1, 1'b0);
        run_burst(30'($urandom), 0, 0, -1, -1, 1'b0, -1, 1'b0);
        run_burst(30'($urandom), 0, -1, -1, 1, 1'b0, -1, 1'b0);
        run_burst(30'($urandom), 3, 0, -1, -1, 1'b0, 3, 1'b0);
        run_burst(30'($urandom), 0, -1, -1, -1, 1'b0, -1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
